// File: rtl/hsv_core_alu_pipe.sv
// Parametrised integer ALU: stage-1 compute, freeze-on-stall delay stages, 2-entry output FIFO.
// Optional macro HSV_ALU_MINMAX_EN enables opcodes 10-13 (MIN/MAX/MINU/MAXU); otherwise they are illegal.
module hsv_core_alu_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 6
) (
  input  logic             clk_core,
  input  logic             rst_core_n,
  input  logic             flush_req,
  output logic             flush_ack,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
    OP_XOR  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_MIN  = 4'd10, OP_MAX  = 4'd11,
    OP_MINU = 4'd12, OP_MAXU = 4'd13
  } op_e;

  typedef struct packed {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } entry_t;

  logic [STAGES-1:0] s_valid_q;
  entry_t            stage_q [STAGES];
  entry_t            buf_q   [2];
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              flush_ack_q;

  logic              stall, accept, push, pop;
  logic              lt_s, lt_u;
  logic [SHW-1:0]    sh;
  entry_t            alu_c;

  assign stall   = (count_q == 2'd2);
  assign ready_o = ~stall & ~flush_req;
  assign accept  = valid_i & ready_o;
  assign push    = s_valid_q[STAGES-1] & ~stall;
  assign valid_o = (count_q != 2'd0);
  assign pop     = valid_o & ready_i;

  assign lt_s = $signed(in_a) < $signed(in_b);
  assign lt_u = in_a < in_b;
  assign sh   = in_b[SHW-1:0];

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    alu_c.res = '0;
    alu_c.tag = in_tag;
    alu_c.ill = 1'b0;
    case (in_op)
      OP_ADD:  alu_c.res = in_a + in_b;
      OP_SUB:  alu_c.res = in_a - in_b;
      OP_AND:  alu_c.res = in_a & in_b;
      OP_OR:   alu_c.res = in_a | in_b;
      OP_XOR:  alu_c.res = in_a ^ in_b;
      OP_SLL:  alu_c.res = in_a << sh;
      OP_SRL:  alu_c.res = in_a >> sh;
      OP_SRA:  alu_c.res = $unsigned($signed(in_a) >>> sh);
      OP_SLT:  alu_c.res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: alu_c.res = {{(XLEN-1){1'b0}}, lt_u};
`ifdef HSV_ALU_MINMAX_EN
      OP_MIN:  alu_c.res = lt_s ? in_a : in_b;
      OP_MAX:  alu_c.res = lt_s ? in_b : in_a;
      OP_MINU: alu_c.res = lt_u ? in_a : in_b;
      OP_MAXU: alu_c.res = lt_u ? in_b : in_a;
`endif
      default: alu_c.ill = 1'b1;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_req) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      if (push && !pop)      count_d = count_q + 2'd1;
      else if (pop && !push) count_d = count_q - 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      s_valid_q   <= '0;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      flush_ack_q <= 1'b1;
    end else begin
      flush_ack_q <= flush_req;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      if (flush_req) begin
        s_valid_q <= '0;
      end else if (!stall) begin
        s_valid_q[0] <= accept;
        for (int i = 1; i < STAGES; i++) s_valid_q[i] <= s_valid_q[i-1];
      end
    end
  end

  // NOTE: payload registers and FIFO storage are not reset; the valid bits and count alone qualify them.
  always_ff @(posedge clk_core) begin
    if (!stall) begin
      stage_q[0] <= alu_c;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
    if (push) buf_q[wr_ptr_q] <= stage_q[STAGES-1];
  end

  assign out_result  = buf_q[rd_ptr_q].res;
  assign out_tag     = buf_q[rd_ptr_q].tag;
  assign out_illegal = buf_q[rd_ptr_q].ill;
  assign flush_ack   = flush_ack_q;

endmodule

// File: tb/tb_hsv_core_alu_pipe.sv
// Self-checking bench for hsv_core_alu_pipe: directed ALU/latency/stall/flush/reset steps plus a
// randomized run scored against an arithmetic reference model and an in-order expected-result queue.
module tb_hsv_core_alu_pipe;
  localparam int XLEN   = 32;
  localparam int TAG_W  = 6;
  parameter  int STAGES = 2;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  tag;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        flush_req = 1'b0, valid_i = 1'b0, ready_i = 1'b1;
  logic [3:0]  in_op = '0;
  logic [31:0] in_a = '0, in_b = '0;
  logic [5:0]  in_tag = '0;
  logic        flush_ack, ready_o, valid_o, out_illegal;
  logic [31:0] out_result;
  logic [5:0]  out_tag;

  int   n_tests = 0, n_fail = 0;
  exp_t exp_q[$];
  logic exp_ack = 1'b1, prev_flush = 1'b0, hold_pend = 1'b0;
  logic [38:0] hold_snap = '0;
  logic s_valid = 1'b0, accepted = 1'b0;
  logic ovr_en = 1'b0, ovr_ill = 1'b0;
  logic [31:0] ovr_res = '0;

  hsv_core_alu_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk_core(clk), .rst_core_n(rst_n), .flush_req(flush_req), .flush_ack(flush_ack),
    .valid_i(valid_i), .ready_o(ready_o), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_tag(in_tag), .valid_o(valid_o), .ready_i(ready_i), .out_result(out_result),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {illegal, result}, computed directly from the opcode definitions.
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned s  = b % 32;
    int          sa = a;
    int          sb = b;
    logic [31:0] r  = '0;
    logic        il = 1'b0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << s;
      4'd6:  r = a >> s;
      4'd7:  r = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      4'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  r = (a < b) ? 32'd1 : 32'd0;
`ifdef HSV_ALU_MINMAX_EN
      4'd10: r = (sa < sb) ? a : b;
      4'd11: r = (sa > sb) ? a : b;
      4'd12: r = (a < b) ? a : b;
      4'd13: r = (a > b) ? a : b;
`endif
      default: il = 1'b1;
    endcase
    return {il, r};
  endfunction

  // One clock: sample at the falling edge, score, then advance past the rising edge.
  task automatic tick();
    exp_t        e;
    logic [32:0] m;
    @(negedge clk);
    s_valid  = valid_o;
    accepted = 1'b0;
    check("flush_ack", {63'd0, flush_ack}, {63'd0, exp_ack});
    if (prev_flush) check("valid_after_flush", {63'd0, valid_o}, 64'd0);
    if (hold_pend) check("output_hold", {24'd0, valid_o, out_result, out_tag, out_illegal}, {24'd0, 1'b1, hold_snap});
    if (flush_req) begin
      check("ready_in_flush", {63'd0, ready_o}, 64'd0);
      exp_q.delete();
    end else begin
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", {63'd0, valid_o}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("result",  {32'd0, out_result},  {32'd0, e.res});
          check("tag",     {58'd0, out_tag},     {58'd0, e.tag});
          check("illegal", {63'd0, out_illegal}, {63'd0, e.ill});
        end
      end
      if (valid_i && ready_o) begin
        m     = ref_alu(in_op, in_a, in_b);
        e.res = ovr_en ? ovr_res : m[31:0];
        e.ill = ovr_en ? ovr_ill : m[32];
        e.tag = in_tag;
        exp_q.push_back(e);
        accepted = 1'b1;
      end
    end
    hold_pend  = valid_o && !ready_i && !flush_req;
    hold_snap  = {out_result, out_tag, out_illegal};
    prev_flush = flush_req;
    exp_ack    = flush_req;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag);
    valid_i = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (accepted) break;
    end
    if (!accepted) check("accept_timeout", {63'd0, accepted}, 64'd1);
    valid_i = 1'b0;
  endtask

  task automatic sendx(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag, input logic [31:0] res, input logic ill);
    ovr_en = 1'b1; ovr_res = res; ovr_ill = ill;
    send(op, a, b, tag);
    ovr_en = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    tick();
    check("idle_valid_o", {63'd0, s_valid}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 4)
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          k, sent;
    logic [3:0]  ops [8];
    logic [31:0] as [8], bs [8];

    // Reset, then idle.
    #12;
    check("rst_valid_o",   {63'd0, valid_o},   64'd0);
    check("rst_flush_ack", {63'd0, flush_ack}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    tick();

    // Directed ALU cases; the first also measures latency.
    sendx(4'd0, 32'hFFFF_FFFF, 32'h1, 6'd5, 32'h0, 1'b0);
    k = 0;
    do begin tick(); k++; end while (!s_valid && k < 20);
    check("latency", 64'(k), 64'(STAGES + 1));
    sendx(4'd7,  32'h8000_0000, 32'h24, 6'd1, 32'hF800_0000, 1'b0);
    sendx(4'd8,  32'hFFFF_FFFF, 32'h1,  6'd2, 32'h1, 1'b0);
    sendx(4'd9,  32'hFFFF_FFFF, 32'h1,  6'd3, 32'h0, 1'b0);
    sendx(4'd14, 32'h1234_5678, 32'h9,  6'd4, 32'h0, 1'b1);
`ifdef HSV_ALU_MINMAX_EN
    sendx(4'd11, 32'hFFFF_FFFF, 32'h1,  6'd6, 32'h1, 1'b0);
    sendx(4'd13, 32'hFFFF_FFFF, 32'h1,  6'd7, 32'hFFFF_FFFF, 1'b0);
`else
    sendx(4'd11, 32'hFFFF_FFFF, 32'h1,  6'd6, 32'h0, 1'b1);
    sendx(4'd13, 32'hFFFF_FFFF, 32'h1,  6'd7, 32'h0, 1'b1);
`endif
    drain();

    // Eight back-to-back ops into a stalled downstream, then release.
    for (int i = 0; i < 8; i++) begin
      ops[i] = 4'($urandom % 10); as[i] = pick(); bs[i] = pick();
    end
    ready_i = 1'b0;
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      valid_i = (sent < 8);
      if (sent < 8) begin in_op = ops[sent]; in_a = as[sent]; in_b = bs[sent]; in_tag = 6'(sent); end
      tick();
      if (accepted) sent++;
    end
    check("stall_accepts", 64'(sent), 64'(STAGES + 2));
    check("stall_ready_o", {63'd0, ready_o}, 64'd0);
    check("stall_valid_o", {63'd0, valid_o}, 64'd1);
    ready_i = 1'b1;
    for (int c = 0; c < 40 && sent < 8; c++) begin
      valid_i = 1'b1; in_op = ops[sent]; in_a = as[sent]; in_b = bs[sent]; in_tag = 6'(sent);
      tick();
      if (accepted) sent++;
    end
    valid_i = 1'b0;
    check("stall_sent_all", 64'(sent), 64'd8);
    drain();

    // Flush with the stages and the buffer both full.
    ready_i = 1'b0;
    sent = 0;
    for (int c = 0; c < 20 && sent < STAGES + 2; c++) begin
      valid_i = 1'b1; in_op = 4'd0; in_a = $urandom; in_b = $urandom; in_tag = 6'(sent);
      tick();
      if (accepted) sent++;
    end
    tick();
    flush_req = 1'b1; valid_i = 1'b1;
    tick();
    flush_req = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    check("flush_empty", {63'd0, valid_o}, 64'd0);

    // Randomized traffic with random backpressure and occasional flushes.
    for (int c = 0; c < 400; c++) begin
      flush_req = ($urandom % 50) == 0;
      valid_i   = ($urandom % 4) != 0;
      ready_i   = ($urandom % 4) != 0;
      in_op     = 4'($urandom);
      in_a      = pick();
      in_b      = (($urandom % 2) == 0) ? 32'($urandom % 64) : pick();
      in_tag    = 6'($urandom);
      tick();
    end
    flush_req = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    drain();

    // Asynchronous reset in the middle of traffic.
    ready_i = 1'b0;
    send(4'd1, 32'h10, 32'h3, 6'd9);
    send(4'd2, 32'hF0, 32'h3C, 6'd10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid_o",   {63'd0, valid_o},   64'd0);
    check("async_rst_flush_ack", {63'd0, flush_ack}, 64'd1);
    exp_q.delete();
    hold_pend = 1'b0; prev_flush = 1'b0; exp_ack = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; ready_i = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    send(4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 6'd11);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hsv_core_alu_pipe.md
Name: hsv_core_alu_pipe

Overview:
Parametrised successor to the fixed two-stage integer ALU. Data width, pipeline depth and tag width are configurable, and there is an explicit opcode port and an illegal-op flag. It sits between issue and commit and uses the same valid/ready and flush_req/flush_ack protocol. Internally it is a freeze-on-stall register pipeline feeding a 2-entry output buffer.

Parameters:
XLEN, 32, operand/result width; power of two, 8..64
STAGES, 2, number of compute register stages; 1..4
TAG_W, 6, width of the opaque tag carried alongside each op

Ports:
clk_core  input  1  core clock
rst_core_n  input  1  asynchronous active-low reset
flush_req  input  1  discard all in-flight and buffered ops
flush_ack  output  1  flush_req registered one cycle
valid_i  input  1  input op valid
ready_o  output  1  input op accepted when valid_i && ready_o
in_op  input  4  opcode; encoding in Behaviour
in_a  input  XLEN  operand A
in_b  input  XLEN  operand B
in_tag  input  TAG_W  opaque tag
valid_o  output  1  result valid
ready_i  input  1  downstream accepts result
out_result  output  XLEN  result
out_tag  output  TAG_W  tag of the op producing out_result
out_illegal  output  1  op was unsupported; out_result is 0

Behaviour:
- Reset values: valid_o=0, flush_ack=1, all stage valids=0, buffer count=0. out_result, out_tag and out_illegal are don't-care while valid_o=0.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MIN, 11 MAX, 12 MINU, 13 MAXU (10-13 optional), 14-15 illegal.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN. Shift amount is in_b[$clog2(XLEN)-1:0]; upper bits are ignored. SLT/SLTU return 1 or 0, zero-extended. SLT/MIN/MAX are signed two's complement.
- Illegal op: out_result=0, out_illegal=1. The op still flows through the pipeline and completes normally.
- Pipeline: STAGES register stages; the op is computed in stage 1, and later stages are pure delay. Each stage carries valid, result, tag and illegal.
- Output buffer: 2-entry FIFO. valid_o = (count!=0). The head drives the outputs.
- Stall: stall = (count==2). While stalled, all stage registers hold. ready_o = ~stall && ~flush_req.
- A stage-STAGES valid pushes into the buffer when not stalled. Push and pop in the same cycle leave count unchanged.
- Latency: with an empty buffer and ready_i=1, valid_o rises exactly STAGES+1 cycles after acceptance. Throughput is 1 op/cycle.
- Ordering is strictly in order.
- Output hold: once valid_o=1, out_result, out_tag and out_illegal stay stable until the cycle where ready_i=1.
- No op is ever dropped or duplicated under any ready_i pattern.
- Flush: on a cycle with flush_req=1, all stage valids and count clear at the next edge, and the input is not accepted that cycle. Any pop in that cycle is superseded by the clear. flush_ack<=flush_req each edge.
- Async reset mid-operation: all ops are lost, and outputs return to reset values immediately.

Optional Feature:
HSV_ALU_MINMAX_EN:
- Defined: opcodes 10-13 compute MIN/MAX/MINU/MAXU, with out_illegal=0.
- Undefined: opcodes 10-13 are treated as illegal (result 0, out_illegal=1), and no comparator-select logic is instantiated.

Test Plan:
- Reset then idle: valid_o=0 and flush_ack=1 during reset; flush_ack=0 one cycle after release with flush_req=0.
- XLEN=32, STAGES=2, ready_i=1: ADD 0xFFFFFFFF+1 tag 5 -> result 0x0, tag 5, valid_o 3 cycles after accept. SRA 0x80000000 by 0x24 -> 0xF8000000. SLT -1,1 -> 1. SLTU -1,1 -> 0.
- Back-to-back 8 ops, then ready_i=0 for 6 cycles: ready_o falls once count=2. valid_o holds the first result with stable data. After ready_i=1, all 8 results appear in order with no loss or duplicate.
- Flush with 2 ops in the stages and 2 ops buffered: valid_o=0 the next cycle, and no stale result ever appears. ready_o=0 during the flush_req cycle. flush_ack mirrors flush_req delayed by 1.
- Opcode 14, and opcode 11 without HSV_ALU_MINMAX_EN -> result 0, out_illegal=1. With the macro, MAX 0xFFFFFFFF,0x1 -> 0x1 and MAXU -> 0xFFFFFFFF.
- STAGES=1 and STAGES=4, random ops with random ready_i against a reference model: results match, and latency is STAGES+1 when unstalled.
